// File: rtl/design_48_pkg.sv
// Shared types and constants for the design_48 initiator-side host.
package design_48_pkg;

  // Host sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Watchdog counter width; bounds TIMEOUT to 1..255.
  localparam int unsigned WD_W = 8;

  // Default operand/result width of the compute block.
  localparam int unsigned DEF_W = 16;

endpackage : design_48_pkg

// File: rtl/design_48_host_if.sv
// Operand stream, result stream and compute-block port bundle for design_48_host.
interface design_48_host_if
  import design_48_pkg::*;
#(
  parameter int unsigned W = DEF_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_err;
  logic         busy;
  logic         dut_start;
  logic [W-1:0] dut_a;
  logic [W-1:0] dut_b;
  logic [W-1:0] dut_y;
  logic         dut_valid;

  // Environment side: produces operands, consumes results, plays the compute block.
  modport master (
    output in_valid, in_a, in_b, out_ready, dut_y, dut_valid,
    input  in_ready, out_valid, out_y, out_err, busy, dut_start, dut_a, dut_b
  );

  // Host side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready, dut_y, dut_valid,
    output in_ready, out_valid, out_y, out_err, busy, dut_start, dut_a, dut_b
  );

endinterface : design_48_host_if

// File: rtl/design_48_host_fifo.sv
// Operand-pair FIFO: 2*W wide, DEPTH entries, pointers wrap modulo DEPTH.
module design_48_host_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [2*W-1:0]               wdata,
  input  logic                         pop,
  output logic [2*W-1:0]               rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count_nxt_c
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [2*W-1:0] mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count_nxt_c = count_d;

  // Pointer and occupancy update; simultaneous push/pop keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule : design_48_host_fifo

// File: rtl/design_48_host.sv
// Initiator-side driver: buffers operand pairs, issues them to the compute
// block one at a time, returns results (or timeouts) on a result stream.
module design_48_host
  import design_48_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst_n,
  design_48_host_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            dut_start_q, dut_start_d;
  logic [W-1:0]    dut_a_q, dut_a_d;
  logic [W-1:0]    dut_b_q, dut_b_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_y_q, out_y_d;
  logic            out_err_q, out_err_d;
  logic            busy_q, busy_d;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [2*W-1:0]  fifo_rdata;
  logic [CW-1:0]   fifo_count_nxt;

  assign bus.in_ready = !fifo_full;
  assign fifo_push    = bus.in_valid && !fifo_full;

  design_48_host_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (fifo_push),
    .wdata       ({bus.in_a, bus.in_b}),
    .pop         (fifo_pop),
    .rdata       (fifo_rdata),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count_nxt_c (fifo_count_nxt)
  );

  // Next-state, watchdog and registered-output computation.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    dut_start_d = 1'b0;
    dut_a_d     = dut_a_q;
    dut_b_d     = dut_b_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_err_d   = out_err_q;
    fifo_pop    = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          dut_a_d     = fifo_rdata[2*W-1:W];
          dut_b_d     = fifo_rdata[W-1:0];
          dut_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.dut_valid) begin
          out_y_d     = bus.dut_y;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (wd_q == WD_W'(TIMEOUT)) begin
          out_y_d     = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || (fifo_count_nxt != '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      dut_start_q <= 1'b0;
      dut_a_q     <= '0;
      dut_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      dut_start_q <= dut_start_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_err_q   <= out_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.dut_start = dut_start_q;
  assign bus.dut_a     = dut_a_q;
  assign bus.dut_b     = dut_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_err   = out_err_q;
  assign bus.busy      = busy_q;

endmodule : design_48_host

// File: tb/tb_design_48_host.sv
// Scoreboard bench for design_48_host with a compute-block model (y = a + b).
module tb_design_48_host;
  localparam int W       = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic [W-1:0] y;
    logic         err;
    int           delta;  // negedges from start seen to out_valid seen
  } exp_t;

  logic clk;
  logic rst_n;
  int   vec;
  int   miss;
  bit   rnd_rdy;

  exp_t exp_q[$];
  int   lat_q[$];

  design_48_host_if #(.W(W)) bus ();

  design_48_host #(
    .W       (W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    vec++;
    miss++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Result a transaction must produce, from operands and the model's reply delay
  // (0 = never replies). A reply after TIMEOUT+1 WAIT cycles is too late.
  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    exp_t e;
    if (lat >= 1 && lat <= TIMEOUT + 1) begin
      e.y = W'(a + b); e.err = 1'b0; e.delta = lat + 1;
    end else begin
      e.y = '0; e.err = 1'b1; e.delta = TIMEOUT + 2;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic try_push(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                          input int budget, output bit ok);
    ok = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        exp_q.push_back(ref_model(a, b, lat));
        lat_q.push_back(lat);
      end
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin step(); n++; end
    if (!bus.out_valid) flag("wait_valid_timeout");
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin step(); n++; end
    if (exp_q.size() != 0) flag("drain_timeout");
    step(); step();
    chk("idle_busy", 64'(bus.busy), 64'(0));
  endtask

  // Compute-block model: replies lat cycles after a start, using held operands.
  initial begin : compute_model
    int cnt;
    cnt = 0;
    bus.dut_valid = 1'b0;
    bus.dut_y = '0;
    forever begin
      @(negedge clk);
      bus.dut_valid = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.dut_valid = 1'b1;
            bus.dut_y = W'(bus.dut_a + bus.dut_b);
          end
        end
        if (bus.dut_start) cnt = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
      end
    end
  end

  // Monitor: start pulse shape, result latency, hold stability, result contents.
  initial begin : monitor
    logic         prev_start, prev_valid, prev_err;
    logic [W-1:0] prev_y;
    int           cyc, start_cyc;
    exp_t         e;
    prev_start = 1'b0; prev_valid = 1'b0; prev_err = 1'b0; prev_y = '0;
    cyc = 0; start_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_start = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (bus.dut_start) begin
          chk("start_one_cycle", 64'(prev_start), 64'(0));
          chk("start_while_result", 64'(bus.out_valid), 64'(0));
          start_cyc = cyc;
        end
        if (bus.out_valid && !prev_valid) begin
          if (exp_q.size() == 0) flag("unexpected_result");
          else chk("result_latency", 64'(cyc - start_cyc), 64'(exp_q[0].delta));
        end
        if (bus.out_valid && prev_valid) begin
          chk("hold_y", 64'(bus.out_y), 64'(prev_y));
          chk("hold_err", 64'(bus.out_err), 64'(prev_err));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            flag("unexpected_handoff");
          end else begin
            e = exp_q.pop_front();
            chk("out_y", 64'(bus.out_y), 64'(e.y));
            chk("out_err", 64'(bus.out_err), 64'(e.err));
          end
        end
        prev_start = bus.dut_start;
        prev_valid = bus.out_valid;
        prev_y     = bus.out_y;
        prev_err   = bus.out_err;
      end
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation bound exceeded");
  end

  initial begin : main
    bit ok;
    int acc;
    int lat;
    vec = 0; miss = 0; rnd_rdy = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;

    // Reset values.
    step(); step();
    chk("rst_dut_start", 64'(bus.dut_start), 64'(0));
    chk("rst_dut_a", 64'(bus.dut_a), 64'(0));
    chk("rst_dut_b", 64'(bus.dut_b), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_y", 64'(bus.out_y), 64'(0));
    chk("rst_out_err", 64'(bus.out_err), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    rst_n = 1'b1;
    step();

    // Single op: 3 + 5 with a two-cycle reply.
    bus.out_ready = 1'b1;
    try_push(16'd3, 16'd5, 2, 20, ok);
    if (!ok) flag("single_push");
    @(negedge clk);
    chk("single_no_early_start", 64'(bus.dut_start), 64'(0));
    @(negedge clk);
    chk("single_start", 64'(bus.dut_start), 64'(1));
    chk("single_dut_a", 64'(bus.dut_a), 64'(3));
    chk("single_dut_b", 64'(bus.dut_b), 64'(5));
    repeat (2) begin
      @(negedge clk);
      chk("wait_dut_a", 64'(bus.dut_a), 64'(3));
      chk("wait_dut_b", 64'(bus.dut_b), 64'(5));
      chk("wait_no_start", 64'(bus.dut_start), 64'(0));
    end
    step();
    drain(50);

    // Full FIFO with a silent compute block and result backpressure.
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      lat = (i == 0) ? 0 : i + 1;
      try_push(W'(16'h100 + i), W'(16'h20 * i), lat, 3, ok);
      if (ok) acc++;
    end
    chk("full_accepted", 64'(acc), 64'(5));
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    bus.out_ready = 1'b1;
    drain(300);

    // Timeout with a late reply arriving while the error result is held.
    bus.out_ready = 1'b0;
    try_push(16'd1, 16'd1, TIMEOUT + 3, 20, ok);
    wait_valid(60);
    chk("timeout_err", 64'(bus.out_err), 64'(1));
    chk("timeout_y", 64'(bus.out_y), 64'(0));
    repeat (6) step();
    bus.out_ready = 1'b1;
    drain(50);

    // Result backpressure on 0xBEEF; next start follows the handoff.
    bus.out_ready = 1'b0;
    try_push(16'hBE00, 16'h00EF, 3, 20, ok);
    try_push(16'd7, 16'd9, 2, 20, ok);
    wait_valid(40);
    for (int i = 0; i < 10; i++) begin
      chk("bp_y", 64'(bus.out_y), 64'(16'hBEEF));
      chk("bp_no_start", 64'(bus.dut_start), 64'(0));
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pending", 64'(bus.out_valid), 64'(1));
    @(negedge clk);
    chk("bp_released", 64'(bus.out_valid), 64'(0));
    chk("bp_idle_no_start", 64'(bus.dut_start), 64'(0));
    @(negedge clk);
    chk("bp_next_start", 64'(bus.dut_start), 64'(1));
    step();
    drain(100);

    // Push coincident with the IDLE->ISSUE pop while two entries are buffered.
    bus.out_ready = 1'b0;
    try_push(16'd10, 16'd20, 2, 20, ok);
    try_push(16'd11, 16'd21, 2, 20, ok);
    try_push(16'd12, 16'd22, 2, 20, ok);
    wait_valid(40);
    chk("sim_count_before", 64'(dut.u_fifo.count_q), 64'(2));
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_a = 16'd13; bus.in_b = 16'd23;
    @(negedge clk);
    chk("sim_in_ready", 64'(bus.in_ready), 64'(1));
    if (bus.in_ready) begin
      exp_q.push_back(ref_model(16'd13, 16'd23, 2));
      lat_q.push_back(2);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sim_count_after", 64'(dut.u_fifo.count_q), 64'(2));
    chk("sim_popped", 64'(bus.dut_start), 64'(1));
    step();
    drain(200);

    // Reset while waiting with three entries buffered.
    for (int i = 0; i < 4; i++) try_push(W'(16'h40 + i), W'(16'h50 + i), 0, 20, ok);
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_dut_start", 64'(bus.dut_start), 64'(0));
    chk("rstw_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rstw_busy", 64'(bus.busy), 64'(0));
    exp_q.delete();
    lat_q.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rstw_in_ready", 64'(bus.in_ready), 64'(1));
    repeat (40) step();
    chk("rstw_quiet_busy", 64'(bus.busy), 64'(0));
    chk("rstw_quiet_valid", 64'(bus.out_valid), 64'(0));

    // Randomized traffic with random result backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       lat = 0;
        1:       lat = TIMEOUT + 1;
        2:       lat = TIMEOUT + 2;
        default: lat = int'($urandom_range(1, 4));
      endcase
      try_push(W'($urandom), W'($urandom), lat, 200, ok);
      if (!ok) flag("rand_push_stuck");
      repeat ($urandom_range(0, 2)) step();
    end
    drain(3000);
    rnd_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule : tb_design_48_host

// File: doc/design_48_host.md
Name: design_48_host

Overview:
- Initiator-side driver for the design_48 compute block (start/a/b in, y/valid out).
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues each pair to the compute block with a one-cycle start pulse, waits for its valid, and returns the result on a valid/ready result stream.
- A watchdog flags transactions whose valid never arrives.

Parameters:
W, 16, operand/result width; must match the compute block.
DEPTH, 4, operand FIFO entries; power of 2, ≥2.
TIMEOUT, 15, max cycles in WAIT before error; 1..255.

Ports:
clk  in  1  clock, all logic rising-edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand pair present.
in_ready  out  1  FIFO can accept; equals !full.
in_a  in  W  operand a.
in_b  in  W  operand b.
out_valid  out  1  result present.
out_ready  in  1  result consumer accepts.
out_y  out  W  result value.
out_err  out  1  result is a timeout (out_y = 0).
busy  out  1  FSM not IDLE or FIFO not empty.
dut_start  out  1  start pulse to compute block.
dut_a  out  W  operand a to compute block.
dut_b  out  W  operand b to compute block.
dut_y  in  W  compute block result.
dut_valid  in  1  compute block result valid.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE, FIFO emptied (pointers and count = 0), watchdog = 0.
  - dut_start, dut_a, dut_b, out_valid, out_y, out_err, busy all 0; in_ready = 1.
  - Reset mid-transaction discards FIFO contents and any in-flight result without emitting it.
- FIFO:
  - Push on in_valid & in_ready; pop only on the IDLE->ISSUE transition.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - in_ready is combinational from count (no dependency on in_valid).
  - Data is first-in first-out; no overwrite when full, no pop when empty.
- FSM:
  - IDLE: if FIFO not empty, pop the head into dut_a/dut_b registers and go to ISSUE.
  - ISSUE: dut_start = 1 for exactly this one cycle; clear the watchdog; go to WAIT.
  - WAIT:
    - If dut_valid: out_y <= dut_y, out_err <= 0, out_valid <= 1, go to HOLD.
    - Else if watchdog == TIMEOUT: out_y <= 0, out_err <= 1, out_valid <= 1, go to HOLD.
    - Else watchdog += 1.
  - HOLD: out_valid, out_y and out_err held stable until out_valid & out_ready. In that cycle out_valid <= 0 next and the FSM goes to IDLE.
- Operand hold: dut_a/dut_b are registered and held from the pop until the next pop, stable through the whole WAIT state (the compute block samples its operands one cycle late).
- dut_valid is ignored in IDLE, ISSUE and HOLD; a late valid after timeout is dropped.
- Latency:
  - A push at edge N into an empty FIFO with FSM in IDLE gives dut_start = 1 between edges N+1 and N+2.
  - dut_valid seen in WAIT gives out_valid at the next edge.
  - Back-to-back throughput is one transaction per (compute latency + 3) cycles minimum.
- One transaction in flight at a time; no reordering.
- All outputs except in_ready are registered.

Decomposition:
- Package design_48_pkg:
  - state enum {IDLE, ISSUE, WAIT, HOLD}, 2 bits;
  - localparam for watchdog width (8);
  - default W.
- Sub-module design_48_host_fifo: parameterised W-pair storage (width 2*W, depth DEPTH) with push, pop, full, empty and count. The FSM and watchdog stay in the top level.

Test Plan:
- Single op: push a=3,b=5 at edge N; model asserts dut_valid with y=8 two cycles after start. Required: dut_start high for exactly one cycle starting at N+1, dut_a=3/dut_b=5 stable through WAIT, out_valid=1, out_y=8, out_err=0.
- Full/backpressure: model never asserts valid, out_ready=0, push 6 pairs. Required: 5 accepted (1 popped + 4 buffered), in_ready=0 afterwards, the 6th is held off. A later draining of results emits them in push order.
- Timeout: push a=1,b=1, dut_valid held 0. Required: out_valid rises after TIMEOUT+1 cycles in WAIT with out_err=1 and out_y=0. A dut_valid pulse after that is ignored.
- Result backpressure: result y=0xBEEF with out_ready=0 for 10 cycles. Required: out_y stays 0xBEEF, no new dut_start while in HOLD. out_ready=1 gives handoff in one cycle, then the next start.
- Simultaneous push/pop: FIFO holding 2 entries, push coincident with the IDLE->ISSUE pop. Required: count stays 2, the new pair is last out.
- Reset mid-WAIT: with 3 entries buffered, pull rst_n low. Required: immediately dut_start=0, out_valid=0, busy=0. After release, in_ready=1 and no result is emitted for the discarded entries.
